// File: rtl/max_rank_ctrl_pkg.sv
// Shared constants for the top-N peak ranking sequencer.
// State codes and signed-range helpers used across the block.
package max_rank_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  function automatic logic [31:0] smin_f(input int dw);
    return 32'd1 << (dw - 1);
  endfunction

  function automatic logic [31:0] smax_f(input int dw);
    return smin_f(dw) - 32'd1;
  endfunction

endpackage

// File: rtl/max_rank_ctrl_timeout_cnt.sv
// Per-pass wait counter: cleared on issue, counts while waiting,
// flags expiry on its last allowed cycle.
module rank_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16384,
  parameter int TO_WIDTH    = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_WIDTH-1:0] cnt;

  assign expired = (cnt == TO_WIDTH'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TO_WIDTH'(1);
    end
  end

endmodule

// File: rtl/max_rank_ctrl.sv
// Top-N distinct-peak extractor: reruns the limited-max finder,
// lowering its limit below each new peak.
module max_rank_ctrl #(
  parameter int DATA_WIDTH  = 18,
  parameter int RANK_NUM    = 4,
  parameter int RANK_WIDTH  = 4,
  parameter int GUARD       = 1,
  parameter int TIMEOUT_CYC = 16384,
  parameter int TO_WIDTH    = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           trig,
  output logic                           fm_start,
  output logic [DATA_WIDTH-1:0]          fm_limit,
  input  logic [DATA_WIDTH-1:0]          fm_max,
  input  logic                           fm_dready,
  output logic [RANK_NUM*DATA_WIDTH-1:0] rank_val,
  output logic [RANK_WIDTH-1:0]          rank_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout
);

  import max_rank_ctrl_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] SMIN = DW'(smin_f(DW));
  localparam logic [DW-1:0] SMAX = DW'(smax_f(DW));

  logic [2:0]            state, state_nx;
  logic [RANK_WIDTH-1:0] idx, idx_d;
  logic [RANK_WIDTH-1:0] cnt_d;
  logic [DW-1:0]         max_q, max_d;
  logic [DW-1:0]         limit_d;
  logic                  start_d, busy_d, done_d, to_d;
  logic [DW-1:0]         slot [RANK_NUM];
  logic                  to_exp;
  logic                  go, wr_slot;
  logic signed [DW:0]    dec;
  logic                  lim_ok, is_none, last;

  rank_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_WIDTH   (TO_WIDTH)
  ) u_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == S_ISSUE),
    .en     ((state == S_WAIT) && !fm_dready),
    .expired(to_exp)
  );

  // Next limit computed one bit wider so SMIN-adjacent peaks cannot wrap.
  assign dec     = $signed({max_q[DW-1], max_q})
                 - $signed((DW + 1)'(GUARD));
  assign lim_ok  = dec > $signed({SMIN[DW-1], SMIN});
  assign is_none = (max_q == SMIN);
  assign last    = (idx == RANK_WIDTH'(RANK_NUM - 1));
  assign go      = (state == S_IDLE) && trig;
  assign wr_slot = (state == S_STORE) && !is_none;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      rank_cnt <= '0;
      max_q    <= SMIN;
      fm_limit <= SMAX;
      fm_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      for (int k = 0; k < RANK_NUM; k++) slot[k] <= SMIN;
    end else begin
      state    <= state_nx;
      idx      <= idx_d;
      rank_cnt <= cnt_d;
      max_q    <= max_d;
      fm_limit <= limit_d;
      fm_start <= start_d;
      busy     <= busy_d;
      done     <= done_d;
      timeout  <= to_d;
      if (go) begin
        for (int k = 0; k < RANK_NUM; k++) slot[k] <= SMIN;
      end else if (wr_slot) begin
        slot[idx] <= max_q;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (trig) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (fm_dready)   state_nx = S_STORE;
        else if (to_exp) state_nx = S_FIN;
      end
      S_STORE: begin
        if (is_none || last || !lim_ok) state_nx = S_FIN;
        else                            state_nx = S_ISSUE;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start_d = (state_nx == S_ISSUE);
    done_d  = (state_nx == S_FIN);
    busy_d  = (state_nx == S_ISSUE) || (state_nx == S_WAIT)
           || (state_nx == S_STORE);
    to_d    = timeout;
    idx_d   = idx;
    cnt_d   = rank_cnt;
    max_d   = max_q;
    limit_d = fm_limit;
    if (go) begin
      to_d    = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      limit_d = SMAX;
    end
    if ((state == S_WAIT) && fm_dready) max_d = fm_max;
    if ((state == S_WAIT) && !fm_dready && to_exp) to_d = 1'b1;
    if (wr_slot) cnt_d = idx + RANK_WIDTH'(1);
    if ((state == S_STORE) && (state_nx == S_ISSUE)) begin
      limit_d = dec[DW-1:0];
      idx_d   = idx + RANK_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < RANK_NUM; k++) begin : g_out
    assign rank_val[k*DW +: DW] = slot[k];
  end

endmodule
